// File: rtl/commit_sequencer.sv
// In-order retirement of up to NrCommitPorts oldest scoreboard entries.
// Also serialises fences, pulses retired exceptions and counts retired instructions.
module commit_sequencer #(
   parameter int NrCommitPorts = 2,
   parameter int XLEN          = 64,
   parameter int CntWidth      = 64
) (
   input  logic                                clk_i,
   input  logic                                rst_ni,
   input  logic                                flush_i,
   input  logic                                halt_i,
   input  logic [NrCommitPorts-1:0]            sb_valid_i,
   input  logic [NrCommitPorts-1:0]            sb_drop_i,
   input  logic [NrCommitPorts-1:0][1:0]       sb_kind_i,
   input  logic [NrCommitPorts-1:0]            sb_ex_valid_i,
   input  logic [NrCommitPorts-1:0][4:0]       sb_rd_i,
   input  logic [NrCommitPorts-1:0][XLEN-1:0]  sb_result_i,
   output logic [NrCommitPorts-1:0]            commit_ack_o,
   output logic [NrCommitPorts-1:0]            we_gpr_o,
   output logic [NrCommitPorts-1:0][4:0]       waddr_o,
   output logic [NrCommitPorts-1:0][XLEN-1:0]  wdata_o,
   output logic                                commit_lsu_o,
   input  logic                                commit_lsu_ready_i,
   output logic                                fence_req_o,
   input  logic                                fence_done_i,
   output logic                                ex_valid_o,
   output logic [CntWidth-1:0]                 commit_count_o
);

   typedef enum logic {IDLE, FENCE_WAIT} state_e;

   localparam logic [1:0] KIND_ALU   = 2'd0;
   localparam logic [1:0] KIND_STORE = 2'd1;
   localparam logic [1:0] KIND_CSR   = 2'd2;
   localparam logic [1:0] KIND_FENCE = 2'd3;

   state_e                     state_q, state_d;
   logic                       done_q, done_d;
   logic                       fence_req_q, fence_req_d;
   logic                       ex_valid_q, ex_valid_d;
   logic [CntWidth-1:0]        count_q, count_d;
   logic [NrCommitPorts-1:0]   ack;
   logic [NrCommitPorts-1:0]   we;
   logic [CntWidth-1:0]        cnt_inc;

   always_comb begin
      state_d      = state_q;
      done_d       = done_q;
      fence_req_d  = fence_req_q;
      ack          = '0;
      we           = '0;
      commit_lsu_o = 1'b0;
      cnt_inc      = '0;

      if (flush_i) begin
         state_d     = IDLE;
         done_d      = 1'b0;
         fence_req_d = 1'b0;
      end else if (state_q == IDLE) begin
         if (!halt_i && sb_valid_i[0]) begin
            if (sb_drop_i[0] || sb_ex_valid_i[0]) begin
               ack[0] = 1'b1;
            end else begin
               unique case (sb_kind_i[0])
                  KIND_STORE: begin
                     commit_lsu_o = 1'b1;
                     ack[0]       = commit_lsu_ready_i;
                  end
                  KIND_FENCE: begin
                     state_d     = FENCE_WAIT;
                     fence_req_d = 1'b1;
                  end
                  default: ack[0] = 1'b1;
               endcase
            end
         end
      end else begin
         // A completion seen during halt is remembered in done_q until release
         if (!halt_i && (fence_done_i || done_q)) begin
            ack[0]      = 1'b1;
            state_d     = IDLE;
            fence_req_d = 1'b0;
            done_d      = 1'b0;
         end else if (fence_done_i) begin
            done_d = 1'b1;
         end
      end

      // Younger ports only retire behind a plain ALU (or squashed) predecessor
      for (int k = 1; k < NrCommitPorts; k++) begin
         ack[k] = ack[k-1]
                & (sb_drop_i[k-1] | (sb_kind_i[k-1] == KIND_ALU && !sb_ex_valid_i[k-1]))
                & sb_valid_i[k]
                & (sb_drop_i[k] | (sb_kind_i[k] == KIND_ALU && !sb_ex_valid_i[k]));
      end

      for (int k = 0; k < NrCommitPorts; k++) begin
         we[k] = ack[k] & ~sb_drop_i[k] & ~sb_ex_valid_i[k]
               & (sb_kind_i[k] == KIND_ALU || sb_kind_i[k] == KIND_CSR)
               & (sb_rd_i[k] != 5'd0);
         if (ack[k] && !sb_drop_i[k] && !sb_ex_valid_i[k]) begin
            cnt_inc = cnt_inc + CntWidth'(1);
         end
      end

      ex_valid_d = ack[0] & ~sb_drop_i[0] & sb_ex_valid_i[0];
      count_d    = count_q + cnt_inc;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         done_q      <= 1'b0;
         fence_req_q <= 1'b0;
         ex_valid_q  <= 1'b0;
         count_q     <= '0;
      end else begin
         state_q     <= state_d;
         done_q      <= done_d;
         fence_req_q <= fence_req_d;
         ex_valid_q  <= ex_valid_d;
         count_q     <= count_d;
      end
   end

   assign commit_ack_o   = ack;
   assign we_gpr_o       = we;
   assign waddr_o        = sb_rd_i;
   assign wdata_o        = sb_result_i;
   assign fence_req_o    = fence_req_q;
   assign ex_valid_o     = ex_valid_q;
   assign commit_count_o = count_q;

endmodule

// File: doc/commit_sequencer.md
# commit_sequencer

Retirement sequencer between the scoreboard's commit ports and the architectural state. Each cycle it inspects the (up to two) oldest scoreboard entries and decides which to retire in order. It drives the commit acknowledges, GPR write ports and the store-buffer commit handshake. It runs a small FSM that serialises fences, and it keeps a registered exception pulse and a retired-instruction counter.

## Interface
- NrCommitPorts, 2, number of commit ports (1 or 2)
- XLEN, 64, data width
- CntWidth, 64, width of retired-instruction counter

- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- flush_i  in  1  controller flush; aborts fence wait, clears latched state
- halt_i  in  1  controller halt; no retirement while high
- sb_valid_i  in  [N]  entry result valid (port k = commit_pointer+k)
- sb_drop_i  in  [N]  entry cancelled (speculative squash)
- sb_kind_i  in  [N][1:0]  0 = ALU/other, 1 = STORE, 2 = CSR, 3 = FENCE
- sb_ex_valid_i  in  [N]  entry carries exception
- sb_rd_i  in  [N][4:0]  destination register
- sb_result_i  in  [N][XLEN]  result data
- commit_ack_o  out  [N]  retire entry k this cycle
- we_gpr_o  out  [N]  GPR write enable
- waddr_o  out  [N][4:0]  GPR write address
- wdata_o  out  [N][XLEN]  GPR write data
- commit_lsu_o  out  1  request store-buffer commit of port-0 store
- commit_lsu_ready_i  in  1  store buffer accepts commit this cycle
- fence_req_o  out  1  fence request to caches, registered
- fence_done_i  in  1  fence complete, 1-cycle pulse
- ex_valid_o  out  1  exception retired, registered 1-cycle pulse
- commit_count_o  out  CntWidth  retired instructions, registered

## Operation
- FSM states: IDLE, FENCE_WAIT.
- Port 0 in IDLE, halt_i=0, sb_valid_i[0]=1:
  - Dropped: ack. No write, no count, no exception.
  - Exception (not dropped): ack, no write, not counted. Sets ex_valid_o next cycle.
  - ALU: ack. we_gpr_o[0] = (rd != 0).
  - CSR: ack. we_gpr_o[0] = (rd != 0).
  - STORE: commit_lsu_o=1. Ack only when commit_lsu_ready_i=1 in the same cycle. No GPR write.
  - FENCE: no ack. Next state FENCE_WAIT, fence_req_o=1 from next cycle.
- FENCE_WAIT:
  - fence_req_o held high, no acks on either port.
  - On fence_done_i with halt_i=0: ack port 0 that cycle (counted), fence_req_o low next cycle, return to IDLE.
  - fence_done_i while halt_i=1: latched in done_q. Ack occurs the first cycle halt_i=0, then return to IDLE.
- Port 1 (only when N=2) is acked iff all of the following hold:
  - port 0 acked this cycle;
  - port 0 was ALU or dropped and had no exception;
  - sb_valid_i[1]=1;
  - port 1 is dropped, or has kind ALU with no exception.
  - Port 1 store/CSR/fence/exception waits to become port 0.
- waddr_o/wdata_o always mirror sb_rd_i/sb_result_i. we_gpr_o[k] is 0 unless commit_ack_o[k].
- commit_count_o adds the number of acked, non-dropped, non-exception entries. Wraps modulo 2^CntWidth. Not cleared by flush.
- flush_i: FSM to IDLE, done_q cleared, fence_req_o low next cycle, all acks forced 0 that cycle. ex_valid_o is still produced for an ack in the previous cycle.

## Timing
- commit_ack_o, we_gpr_o, commit_lsu_o: combinational from inputs and state, same cycle.
- fence_req_o, ex_valid_o, commit_count_o: registered; reflect an event 1 cycle later.
- Reset values: all outputs 0, state IDLE, done_q 0, counter 0.
- Reset during FENCE_WAIT: immediate IDLE, fence_req_o low asynchronously.
- halt_i and flush_i in the same cycle: flush wins.

## Test plan
- Two ALU entries, rd=5 and rd=0, both valid -> ack=2'b11, we_gpr_o=2'b01, waddr_o[0]=5. Counter 0 -> 2 next cycle.
- Port-0 store with commit_lsu_ready_i low 3 cycles then high -> commit_lsu_o high 4 cycles, ack only in 4th. Port 1 ALU acked in the 4th cycle only if port 0 is not a store (expect port 1 not acked).
- Port-0 fence -> fence_req_o high from cycle+1. fence_done_i at cycle+5 -> ack at cycle+5, fence_req_o low at cycle+6, counter +1.
- fence_done_i while halt_i=1, halt released 2 cycles later -> ack on release cycle, no earlier.
- Port-0 exception, port-1 ALU valid -> ack=2'b01, no write, ex_valid_o pulses next cycle, counter unchanged.
- flush_i during FENCE_WAIT -> no ack, fence_req_o low next cycle, state IDLE. Port 0 dropped+port 1 dropped -> ack=2'b11, counter unchanged.
